pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic pipeline boundary register that replaces the per-boundary hand-written stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of `DATA_W` bits plus a valid bit.
- Obeys the core's 6-bit stall vector and a flush input.
- Adds what the fixed-width stage registers lack: a valid qualifier, flush, invalid-payload squashing, saturating stall/bubble counters and a stall-timeout watchdog flag for debug.

Parameters:
- DATA_W, 32, payload width in bits (EX/MEM instance uses 144).
- STALL_W, 6, width of the stall vector.
- STAGE, 3, index of this register's stall bit; downstream bit is STAGE+1.
- NOP_DATA, 0, payload value driven on reset, flush and bubble (DATA_W bits).
- SQUASH_INVALID, 1, 1 = payload forced to NOP_DATA when in_valid=0 on advance.
- CNT_W, 16, width of the performance counters.
- TIMEOUT, 1024, consecutive-hold cycles that raise stall_timeout; legal range 1..2^CNT_W-1.

Ports:
- clk, input, 1, rising-edge clock.
- resetn, input, 1, synchronous reset, active-high.
- stall, input, STALL_W, core stall vector; bit=1 means stop.
- flush, input, 1, discard stage contents (exception/branch).
- in_valid, input, 1, upstream payload valid.
- in_data, input, DATA_W, upstream payload.
- cnt_clear, input, 1, synchronous clear of counters and timeout flag.
- out_valid, output, 1, registered valid.
- out_data, output, DATA_W, registered payload.
- held, output, 1, 1 if the last edge was a hold.
- stall_cnt, output, CNT_W, saturating count of hold cycles.
- bubble_cnt, output, CNT_W, saturating count of bubble insertions.
- stall_timeout, output, 1, sticky watchdog flag.

Behaviour:
- All state updates on posedge clk only; no combinational path from inputs to outputs.
- Reset (resetn=1):
  - out_valid=0, out_data=NOP_DATA, held=0.
  - stall_cnt=0, bubble_cnt=0, stall_timeout=0, internal run counter=0.
  - Reset wins over every other input.
- Stall decode:
  - s_here = stall[STAGE].
  - s_down = stall[STAGE+1] if STAGE+1 < STALL_W, else 0.
- Register update, priority after reset:
  1. flush=1: out_valid=0, out_data=NOP_DATA. Flush wins over any stall value.
  2. s_here=1 and s_down=0 (bubble): out_valid=0, out_data=NOP_DATA; bubble_cnt+1.
  3. s_here=1 and s_down=1 (hold): out_valid and out_data unchanged.
  4. s_here=0 (advance): out_valid=in_valid; out_data=in_data, except NOP_DATA when SQUASH_INVALID=1 and in_valid=0.
- Latency: one cycle from in_* to out_* on advance. A held payload persists unchanged for any number of cycles.
- held = 1 on the edge following a hold decision (case 3), else 0. held is 0 after flush, even when s_here=1.
- stall_cnt:
  - +1 on every edge where s_here=1 and flush=0 and reset=0 (hold or bubble).
  - Saturates at 2^CNT_W-1 with no wrap.
- bubble_cnt: saturates likewise.
- Run counter (internal, CNT_W bits):
  - +1 per hold cycle; cleared on any non-hold edge.
  - Saturates at 2^CNT_W-1.
- stall_timeout:
  - Set on the edge where the run counter reaches TIMEOUT.
  - Sticky until reset or cnt_clear.
- cnt_clear=1:
  - stall_cnt, bubble_cnt, run counter and stall_timeout go to 0 on that edge.
  - Clear beats a simultaneous increment.
  - Does not affect out_valid, out_data or held.
- Reset asserted mid-hold: the held payload is lost and outputs take reset values on that edge.

Test Plan:
- Advance: reset 2 cycles, then in_valid=1, in_data=0x1234_5678, stall=0 -> next cycle out_valid=1, out_data=0x12345678, held=0, counters 0.
- Hold: load 0xA5A5A5A5, then stall=6'b011000 for 5 cycles with in_data changing every cycle -> out_data stays 0xA5A5A5A5, held=1 from the 1st hold edge, stall_cnt=5, bubble_cnt=0.
- Bubble: load 0x11, then stall=6'b001111 for 3 cycles -> out_valid=0, out_data=0 on each, bubble_cnt=3, stall_cnt=3. Then stall=0 with in_data=0x22 -> out_data=0x22.
- Flush priority: hold with stall=6'b011000 and assert flush for 1 cycle -> out_valid=0, out_data=NOP_DATA, held=0, run counter cleared, stall_cnt unchanged on that edge.
- Squash: SQUASH_INVALID=1, in_valid=0, in_data=0xDEAD -> out_data=0. Repeat with SQUASH_INVALID=0 -> out_data=0xDEAD, out_valid=0.
- Watchdog/saturation: CNT_W=4, TIMEOUT=10.
  - Hold 20 cycles -> stall_timeout=1 at the 10th hold edge, stall_cnt saturates at 15.
  - Pulse cnt_clear during a hold -> all counters and the flag are 0 the next cycle.
  - Pulse resetn mid-hold -> out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Pipeline boundary bundle: stall/flush control, upstream payload, registered
// downstream payload and the debug counters of one stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               cnt_clear;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               held;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;
  logic               stall_timeout;

  modport master (
    output stall, flush, in_valid, in_data, cnt_clear,
    input  out_valid, out_data, held, stall_cnt, bubble_cnt, stall_timeout
  );

  modport slave (
    input  stall, flush, in_valid, in_data, cnt_clear,
    output out_valid, out_data, held, stall_cnt, bubble_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: valid-qualified payload that obeys the
// core stall vector and flush, with saturating stall/bubble counters and a watchdog.
module pipe_stage_reg #(
  parameter int              DATA_W         = 32,
  parameter int              STALL_W        = 6,
  parameter int              STAGE          = 3,
  parameter logic [DATA_W-1:0] NOP_DATA     = '0,
  parameter bit              SQUASH_INVALID = 1'b1,
  parameter int              CNT_W          = 16,
  parameter int              TIMEOUT        = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_stage_reg_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } action_e;

  logic              s_here;
  logic              s_down;
  action_e           action;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              held_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  run_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign s_here = bus.stall[STAGE];

  // The last stage in the vector has no downstream stall bit: it can only bubble.
  generate
    if (STAGE + 1 < STALL_W) begin : g_down
      assign s_down = bus.stall[STAGE+1];
    end else begin : g_no_down
      assign s_down = 1'b0;
    end
  endgenerate

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    action = ACT_ADVANCE;
    if (bus.flush)       action = ACT_FLUSH;
    else if (s_here)     action = s_down ? ACT_HOLD : ACT_BUBBLE;
  end

  assign run_inc = sat_inc(run_cnt_q);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= NOP_DATA;
      held_q      <= 1'b0;
    end else begin
      held_q <= (action == ACT_HOLD);
      unique case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= NOP_DATA;
        end
        ACT_HOLD: begin
          out_valid_q <= out_valid_q;
          out_data_q  <= out_data_q;
        end
        default: begin
          out_valid_q <= bus.in_valid;
          out_data_q  <= (SQUASH_INVALID && !bus.in_valid) ? NOP_DATA : bus.in_data;
        end
      endcase
    end
  end

  // Debug counters; a clear request beats any increment on the same edge.
  always_ff @(posedge clk) begin
    if (resetn || bus.cnt_clear) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      run_cnt_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (action == ACT_HOLD || action == ACT_BUBBLE)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (action == ACT_BUBBLE)
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
      if (action == ACT_HOLD) begin
        run_cnt_q <= run_inc;
        if (run_inc == TIMEOUT_C)
          timeout_q <= 1'b1;
      end else begin
        run_cnt_q <= '0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.held          = held_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.bubble_cnt    = bubble_cnt_q;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (default, no squash,
// 4-bit counters with short timeout) share one stimulus stream.
module tb_pipe_stage_reg;

  localparam int DATA_W  = 32;
  localparam int STALL_W = 6;

  logic clk;
  logic resetn;

  logic [STALL_W-1:0] t_stall;
  logic               t_flush;
  logic               t_in_valid;
  logic [DATA_W-1:0]  t_in_data;
  logic               t_cnt_clear;

  int n_checks;
  int n_fail;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .STALL_W(STALL_W), .CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .STALL_W(STALL_W), .CNT_W(16)) bus_b ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .STALL_W(STALL_W), .CNT_W(4))  bus_c ();

  assign bus_a.stall = t_stall;  assign bus_a.flush = t_flush;  assign bus_a.in_valid = t_in_valid;
  assign bus_a.in_data = t_in_data;  assign bus_a.cnt_clear = t_cnt_clear;
  assign bus_b.stall = t_stall;  assign bus_b.flush = t_flush;  assign bus_b.in_valid = t_in_valid;
  assign bus_b.in_data = t_in_data;  assign bus_b.cnt_clear = t_cnt_clear;
  assign bus_c.stall = t_stall;  assign bus_c.flush = t_flush;  assign bus_c.in_valid = t_in_valid;
  assign bus_c.in_data = t_in_data;  assign bus_c.cnt_clear = t_cnt_clear;

  pipe_stage_reg #(.DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(3), .NOP_DATA('0),
                   .SQUASH_INVALID(1'b1), .CNT_W(16), .TIMEOUT(1024))
    dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));

  pipe_stage_reg #(.DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(3), .NOP_DATA('0),
                   .SQUASH_INVALID(1'b0), .CNT_W(16), .TIMEOUT(1024))
    dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  pipe_stage_reg #(.DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(3), .NOP_DATA('0),
                   .SQUASH_INVALID(1'b1), .CNT_W(4), .TIMEOUT(10))
    dut_c (.clk(clk), .resetn(resetn), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    resetn      = 1'b1;
    t_stall     = '0;
    t_flush     = 1'b0;
    t_in_valid  = 1'b0;
    t_in_data   = '0;
    t_cnt_clear = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid",  bus_a.out_valid,     0);
    check("rst_out_data",   bus_a.out_data,      0);
    check("rst_held",       bus_a.held,          0);
    check("rst_stall_cnt",  bus_a.stall_cnt,     0);
    check("rst_bubble_cnt", bus_a.bubble_cnt,    0);
    check("rst_timeout",    bus_a.stall_timeout, 0);
    resetn = 1'b0;

    // Advance
    t_in_valid = 1'b1;
    t_in_data  = 32'h1234_5678;
    tick();
    check("adv_out_valid", bus_a.out_valid, 1);
    check("adv_out_data",  bus_a.out_data,  32'h1234_5678);
    check("adv_held",      bus_a.held,      0);
    check("adv_stall_cnt", bus_a.stall_cnt, 0);

    // Hold with changing upstream data
    t_in_data = 32'hA5A5_A5A5;
    tick();
    check("load_a5_data", bus_a.out_data, 32'hA5A5_A5A5);
    t_stall = 6'b011000;
    for (int i = 0; i < 5; i++) begin
      t_in_data = 32'h0F00_0000 + i;
      tick();
      check("hold_out_data",  bus_a.out_data,  32'hA5A5_A5A5);
      check("hold_out_valid", bus_a.out_valid, 1);
      check("hold_held",      bus_a.held,      1);
    end
    check("hold_stall_cnt",  bus_a.stall_cnt,  5);
    check("hold_bubble_cnt", bus_a.bubble_cnt, 0);

    // Flush beats hold; stall_cnt does not move on the flush edge
    t_flush = 1'b1;
    tick();
    check("flush_out_valid", bus_a.out_valid, 0);
    check("flush_out_data",  bus_a.out_data,  0);
    check("flush_held",      bus_a.held,      0);
    check("flush_stall_cnt", bus_a.stall_cnt, 5);
    check("flush_c_stall",   bus_c.stall_cnt, 5);
    t_flush = 1'b0;
    // C's run counter was 5 before flush; 6 more holds reach 10 only if flush failed to clear it
    for (int i = 0; i < 6; i++) tick();
    check("flush_run_clr_timeout", bus_c.stall_timeout, 0);
    check("post_flush_held",       bus_a.held,          1);
    check("post_flush_stall_cnt",  bus_a.stall_cnt,     11);

    // Bubble, starting from cleared counters
    t_stall     = '0;
    t_in_data   = 32'h11;
    t_cnt_clear = 1'b1;
    tick();
    t_cnt_clear = 1'b0;
    check("clr_keeps_data",  bus_a.out_data,   32'h11);
    check("clr_keeps_valid", bus_a.out_valid,  1);
    check("clr_stall_cnt",   bus_a.stall_cnt,  0);
    t_stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble_out_valid", bus_a.out_valid, 0);
      check("bubble_out_data",  bus_a.out_data,  0);
      check("bubble_held",      bus_a.held,      0);
    end
    check("bubble_cnt",       bus_a.bubble_cnt, 3);
    check("bubble_stall_cnt", bus_a.stall_cnt,  3);
    t_stall   = '0;
    t_in_data = 32'h22;
    tick();
    check("after_bubble_data",  bus_a.out_data,  32'h22);
    check("after_bubble_valid", bus_a.out_valid, 1);

    // Squash of invalid payload versus pass-through
    t_in_valid = 1'b0;
    t_in_data  = 32'hDEAD;
    tick();
    check("squash_data",    bus_a.out_data,  0);
    check("squash_valid",   bus_a.out_valid, 0);
    check("nosquash_data",  bus_b.out_data,  32'hDEAD);
    check("nosquash_valid", bus_b.out_valid, 0);

    // Watchdog and saturation on the 4-bit instance
    t_cnt_clear = 1'b1;
    t_in_valid  = 1'b1;
    t_in_data   = 32'h00C0_FFEE;
    tick();
    t_cnt_clear = 1'b0;
    check("wd_clr_stall_cnt", bus_c.stall_cnt,     0);
    check("wd_clr_timeout",   bus_c.stall_timeout, 0);
    t_stall = 6'b011000;
    for (int i = 0; i < 20; i++) begin
      logic exp_to;
      exp_to = (i >= 9);
      tick();
      check("wd_timeout", bus_c.stall_timeout, exp_to);
    end
    check("wd_stall_sat",  bus_c.stall_cnt,     15);
    check("wd_hold_data",  bus_c.out_data,      32'h00C0_FFEE);
    check("wd_a_no_to",    bus_a.stall_timeout, 0);
    check("wd_a_stall",    bus_a.stall_cnt,     20);

    // Clear during hold: counters and flag drop, payload and held stay
    t_cnt_clear = 1'b1;
    tick();
    t_cnt_clear = 1'b0;
    check("hclr_stall_cnt",  bus_c.stall_cnt,     0);
    check("hclr_bubble_cnt", bus_c.bubble_cnt,    0);
    check("hclr_timeout",    bus_c.stall_timeout, 0);
    check("hclr_held",       bus_c.held,          1);
    check("hclr_data",       bus_c.out_data,      32'h00C0_FFEE);
    tick();
    check("hclr_resume_cnt", bus_c.stall_cnt, 1);

    // Reset in the middle of a hold
    resetn = 1'b1;
    tick();
    check("mrst_out_valid", bus_c.out_valid, 0);
    check("mrst_out_data",  bus_c.out_data,  0);
    check("mrst_held",      bus_c.held,      0);
    check("mrst_stall_cnt", bus_c.stall_cnt, 0);
    resetn  = 1'b0;
    t_stall = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
